filter_channel_scheduler: RTL and testbench

- Time-multiplexes one shared moving-average/CIC filter datapath among CHANNELS sample sources.
- Round-robin arbitration across the sources; issues one sample per handshake to the datapath.
- Each issued sample is tagged with channel id, first-sample (context clear) and emit (decimated output due).
- Tracks per-channel warm-up (delay line filled) and decimation phase, so the datapath needs no per-channel control logic.

---
 rtl/filter_channel_scheduler.sv | 134 +++++++++++++
 tb/tb_filter_channel_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_channel_scheduler.sv
// Round-robin scheduler that time-multiplexes one shared moving-average/CIC datapath
// across CHANNELS sources, tagging each sample with channel, first and emit flags.
module filter_channel_scheduler #(
  parameter int CHANNELS = 4,
  parameter int SIZE     = 8,
  parameter int LENGTH   = 5,
  parameter int DECIM    = 4,
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [CHANNELS-1:0]      i_req_valid,
  input  logic [CHANNELS*SIZE-1:0] i_req_data,
  output logic [CHANNELS-1:0]      o_req_ready,
  input  logic                     i_flush,
  output logic                     o_dp_valid,
  input  logic                     i_dp_ready,
  output logic [SIZE-1:0]          o_dp_data,
  output logic [CHW-1:0]           o_dp_chan,
  output logic                     o_dp_first,
  output logic                     o_dp_emit,
  output logic [CHANNELS-1:0]      o_warm
);

  localparam int FW = $clog2(LENGTH + 1);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [FW-1:0]  LEN_FULL = FW'(LENGTH);
  localparam logic [FW:0]    LEN_WIDE = (FW+1)'(LENGTH);
  localparam logic [DW-1:0]  DEC_LAST = DW'(DECIM - 1);
  localparam logic [CHW:0]   CH_N     = (CHW+1)'(CHANNELS);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(CHANNELS - 1);

  logic [CHW-1:0]  r_ptr;
  logic            r_dp_valid;
  logic [SIZE-1:0] r_dp_data;
  logic [CHW-1:0]  r_dp_chan;
  logic            r_dp_first;
  logic            r_dp_emit;
  logic [FW-1:0]   r_fill [CHANNELS];
  logic [DW-1:0]   r_dec  [CHANNELS];

  logic [2*CHANNELS-1:0] w_dbl;
  logic [CHANNELS-1:0]   w_rot;
  logic [CHW-1:0]        w_off;
  logic [CHW:0]          w_sum;
  logic [CHW-1:0]        w_grant;
  logic                  w_found;
  logic                  w_slot_free;
  logic                  w_issue;
  logic [SIZE-1:0]       w_data [CHANNELS];
  logic [FW-1:0]         w_g_fill;
  logic [DW-1:0]         w_g_dec;
  logic                  w_g_warm;
  logic                  w_g_first;
  logic                  w_g_emit;

  // Rotate requests so bit 0 is the channel at the pointer; lowest set bit wins.
  always_comb begin
    w_slot_free = !r_dp_valid || i_dp_ready;
    w_dbl       = {i_req_valid, i_req_valid} >> r_ptr;
    w_rot       = w_dbl[CHANNELS-1:0];
    w_found     = |w_rot;
    w_off       = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = CHW'(i);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= CH_N) w_sum = w_sum - CH_N;
    w_grant     = w_sum[CHW-1:0];
    w_issue     = w_slot_free && !i_flush && w_found;
    o_req_ready = '0;
    if (w_issue) o_req_ready[w_grant] = 1'b1;
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_data[c] = i_req_data[c*SIZE +: SIZE];
      o_warm[c] = (r_fill[c] == LEN_FULL);
    end
  end

  // A sample is warm once LENGTH-1 samples of the channel have already gone through.
  always_comb begin
    w_g_fill  = r_fill[w_grant];
    w_g_dec   = r_dec[w_grant];
    w_g_first = (w_g_fill == '0);
    w_g_warm  = (({1'b0, w_g_fill} + 1'b1) >= LEN_WIDE);
    w_g_emit  = w_g_warm && (w_g_dec == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr      <= '0;
      r_dp_valid <= 1'b0;
      r_dp_data  <= '0;
      r_dp_chan  <= '0;
      r_dp_first <= 1'b0;
      r_dp_emit  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_fill[c] <= '0;
        r_dec[c]  <= '0;
      end
    end else begin
      if (w_issue) begin
        r_dp_valid <= 1'b1;
        r_dp_data  <= w_data[w_grant];
        r_dp_chan  <= w_grant;
        r_dp_first <= w_g_first;
        r_dp_emit  <= w_g_emit;
        r_ptr      <= (w_grant == CH_LAST) ? '0 : w_grant + 1'b1;
      end else if (i_dp_ready) begin
        r_dp_valid <= 1'b0;
      end
      // Flush never coincides with an issue; the held output sample is left alone.
      if (i_flush) begin
        r_ptr <= '0;
        for (int c = 0; c < CHANNELS; c++) begin
          r_fill[c] <= '0;
          r_dec[c]  <= '0;
        end
      end else if (w_issue) begin
        if (w_g_fill != LEN_FULL) r_fill[w_grant] <= w_g_fill + 1'b1;
        if (w_g_warm) r_dec[w_grant] <= (w_g_dec == DEC_LAST) ? '0 : w_g_dec + 1'b1;
      end
    end
  end

  assign o_dp_valid = r_dp_valid;
  assign o_dp_data  = r_dp_data;
  assign o_dp_chan  = r_dp_chan;
  assign o_dp_first = r_dp_first;
  assign o_dp_emit  = r_dp_emit;

endmodule

// File: tb/tb_filter_channel_scheduler.sv
// Scoreboard bench for filter_channel_scheduler: a default build (4 ch, L=5, D=4)
// and a 3-channel L=1/D=1 build share stimulus and are checked against a k-count model.
module tb_filter_channel_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        flush;
  logic        dp_ready;

  logic [3:0] a_ready, a_warm;
  logic       a_valid, a_first, a_emit;
  logic [7:0] a_data;
  logic [1:0] a_chan;

  logic [2:0] b_ready, b_warm;
  logic       b_valid, b_first, b_emit;
  logic [7:0] b_data;
  logic [1:0] b_chan;

  filter_channel_scheduler #(.CHANNELS(4), .SIZE(8), .LENGTH(5), .DECIM(4)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(a_ready), .i_flush(flush), .o_dp_valid(a_valid), .i_dp_ready(dp_ready),
    .o_dp_data(a_data), .o_dp_chan(a_chan), .o_dp_first(a_first), .o_dp_emit(a_emit),
    .o_warm(a_warm));

  filter_channel_scheduler #(.CHANNELS(3), .SIZE(8), .LENGTH(1), .DECIM(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid[2:0]), .i_req_data(req_data[23:0]),
    .o_req_ready(b_ready), .i_flush(flush), .o_dp_valid(b_valid), .i_dp_ready(dp_ready),
    .o_dp_data(b_data), .o_dp_chan(b_chan), .o_dp_first(b_first), .o_dp_emit(b_emit),
    .o_warm(b_warm));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] chan;
    logic       first;
    logic       emit;
  } item_t;

  item_t q0[$];
  item_t q1[$];

  int checks = 0;
  int errors = 0;

  int  m_k [2][4];
  int  m_ptr [2];
  bit  m_valid [2];
  bit  hold [2];
  item_t held [2];
  bit  held_valid [2];

  function automatic int nch(int u); return (u == 0) ? 4 : 3; endfunction
  function automatic int len(int u); return (u == 0) ? 5 : 1; endfunction
  function automatic int dec(int u); return (u == 0) ? 4 : 1; endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 4; c++) m_k[u][c] = 0;
      m_ptr[u]   = 0;
      m_valid[u] = 0;
      hold[u]    = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Reference: k counts accepted samples per channel; grant is next requester after the last one served.
  task automatic model_step(int u, logic [3:0] rr, logic [3:0] wm);
    logic [3:0] exp_w;
    logic [3:0] exp_rr;
    int grant;
    int k;
    item_t it;
    exp_w = '0;
    for (int c = 0; c < nch(u); c++) exp_w[c] = (m_k[u][c] >= len(u));
    chk((u == 0) ? "a_warm" : "b_warm", 32'(wm), 32'(exp_w));
    grant = -1;
    if ((!m_valid[u] || dp_ready) && !flush) begin
      for (int i = 0; i < nch(u); i++) begin
        int c;
        c = (m_ptr[u] + i) % nch(u);
        if (req_valid[c] && grant < 0) grant = c;
      end
    end
    exp_rr = '0;
    if (grant >= 0) exp_rr[grant] = 1'b1;
    chk((u == 0) ? "a_req_ready" : "b_req_ready", 32'(rr), 32'(exp_rr));
    if (grant >= 0) begin
      k        = m_k[u][grant];
      it.data  = req_data[grant*8 +: 8];
      it.chan  = 2'(grant);
      it.first = (k == 0);
      it.emit  = (k >= len(u) - 1) && (((k - (len(u) - 1)) % dec(u)) == 0);
      if (u == 0) q0.push_back(it); else q1.push_back(it);
      m_k[u][grant] = k + 1;
      m_ptr[u]      = (grant + 1) % nch(u);
      m_valid[u]    = 1;
    end else if (dp_ready) begin
      m_valid[u] = 0;
    end
    if (flush) begin
      for (int c = 0; c < 4; c++) m_k[u][c] = 0;
      m_ptr[u] = 0;
    end
  endtask

  task automatic mon(int u, logic v, logic [7:0] d, logic [1:0] ch, logic f, logic e);
    item_t cur;
    item_t exp;
    bit    got;
    cur = '{data: d, chan: ch, first: f, emit: e};
    if (hold[u]) begin
      chk((u == 0) ? "a_stall_valid" : "b_stall_valid", 32'(v), 32'(held_valid[u]));
      chk((u == 0) ? "a_stall_hold" : "b_stall_hold", 32'(cur), 32'(held[u]));
    end
    if (v && dp_ready) begin
      got = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL %s: got unexpected sample %0h expected none at %0t",
                 (u == 0) ? "a_spurious" : "b_spurious", cur, $time);
      end else begin
        exp = (u == 0) ? q0.pop_front() : q1.pop_front();
        chk((u == 0) ? "a_data" : "b_data", 32'(d), 32'(exp.data));
        chk((u == 0) ? "a_chan" : "b_chan", 32'(ch), 32'(exp.chan));
        chk((u == 0) ? "a_first" : "b_first", 32'(f), 32'(exp.first));
        chk((u == 0) ? "a_emit" : "b_emit", 32'(e), 32'(exp.emit));
      end
    end
    hold[u]       = v && !dp_ready;
    held[u]       = cur;
    held_valid[u] = v;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      model_step(0, a_ready, a_warm);
      model_step(1, {1'b0, b_ready}, {1'b0, b_warm});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, a_valid, a_data, a_chan, a_first, a_emit);
      mon(1, b_valid, b_data, b_chan, b_first, b_emit);
    end
  end

  task automatic cyc(logic [3:0] rv, logic rdy, logic fl);
    @(posedge clk);
    #1;
    req_valid = rv;
    req_data  = $urandom;
    dp_ready  = rdy;
    flush     = fl;
  endtask

  task automatic check_idle(string tag);
    chk({tag, "_a_valid"}, 32'(a_valid), 0);
    chk({tag, "_a_data"},  32'(a_data), 0);
    chk({tag, "_a_chan"},  32'(a_chan), 0);
    chk({tag, "_a_first"}, 32'(a_first), 0);
    chk({tag, "_a_emit"},  32'(a_emit), 0);
    chk({tag, "_a_warm"},  32'(a_warm), 0);
    chk({tag, "_b_valid"}, 32'(b_valid), 0);
    chk({tag, "_b_warm"},  32'(b_warm), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    flush     = 1'b0;
    dp_ready  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    // Single channel 0 streaming.
    repeat (14) cyc(4'b0001, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    // All channels continuously valid.
    repeat (24) cyc(4'b1111, 1'b1, 1'b0);
    // Channels 1 and 3 with a toggling sink.
    for (int i = 0; i < 16; i++) cyc(4'b1010, (i % 2) == 0, 1'b0);
    // Channel 2: six samples, stall, flush while held, then resume.
    cyc(4'b0000, 1'b1, 1'b1);
    repeat (6) cyc(4'b0100, 1'b1, 1'b0);
    repeat (2) cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b1);
    cyc(4'b0100, 1'b0, 1'b0);
    repeat (10) cyc(4'b0100, 1'b1, 1'b0);
    // Random traffic with occasional flushes.
    for (int i = 0; i < 1500; i++)
      cyc(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);

    // Asynchronous reset while a sample is held.
    repeat (4) cyc(4'b1111, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_a_valid", 32'(a_valid), 0);
    chk("midreset_b_valid", 32'(b_valid), 0);
    model_reset();
    req_valid = 4'b1111;
    dp_ready  = 1'b1;
    @(posedge clk);
    #1;
    check_idle("midreset");
    rst_n = 1'b1;
    repeat (12) cyc(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++)
      cyc(4'($urandom), $urandom_range(0, 1) != 0, $urandom_range(0, 31) == 0);

    repeat (6) cyc(4'b0000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("drain_a_queue", 32'(q0.size()), 0);
    chk("drain_b_queue", 32'(q1.size()), 0);
    chk("drain_a_valid", 32'(a_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
